// File: rtl/bcd_display_ctrl.sv
// Sequential binary-to-BCD display controller: a 32-cycle double-dabble conversion plus
// arbitration between halt, wait, blank and converted-value patterns on the 8 digit codes.
module bcd_display_ctrl #(
  parameter logic [3:0] BLANK_CODE = 4'b1010,
  parameter logic [3:0] WAIT_CODE  = 4'b1011,
  parameter logic [3:0] HLT_U      = 4'b1110,
  parameter logic [3:0] HLT_D      = 4'b1101,
  parameter logic [3:0] HLT_C      = 4'b1100
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        outputEnable,
  input  logic        flagw,
  input  logic        notOUT,
  input  logic        HLT,
  input  logic [31:0] dataBin,
  output logic [3:0]  dmilhao,
  output logic [3:0]  milhao,
  output logic [3:0]  cmilhar,
  output logic [3:0]  dmilhar,
  output logic [3:0]  milhar,
  output logic [3:0]  centesimal,
  output logic [3:0]  decimal,
  output logic [3:0]  unidade,
  output logic        busy,
  output logic        done,
  output logic        ovf
);

  typedef enum logic [1:0] {StIdle, StShift, StCommit} state_e;

  localparam logic [31:0] HaltPat = {{5{BLANK_CODE}}, HLT_C, HLT_D, HLT_U};

  state_e      r_state;
  logic [31:0] r_shift;
  logic [39:0] r_acc;
  logic [4:0]  r_cnt;
  logic [31:0] r_dig;
  logic        r_busy;
  logic        r_done;
  logic        r_ovf;
  logic [39:0] w_adj;

  // Add-3 correction on every BCD nibble before the shift.
  always_comb begin
    w_adj = r_acc;
    for (int i = 0; i < 10; i++) begin
      if (r_acc[4*i +: 4] > 4'd4) begin
        w_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= StIdle;
      r_shift <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_dig   <= {8{BLANK_CODE}};
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (HLT) begin
            r_dig <= HaltPat;
            r_ovf <= 1'b0;
          end else if (outputEnable) begin
            r_shift <= dataBin;
            r_acc   <= '0;
            r_cnt   <= 5'd31;
            r_busy  <= 1'b1;
            r_state <= StShift;
          end else if (flagw) begin
            r_dig <= {8{WAIT_CODE}};
            r_ovf <= 1'b0;
          end else if (notOUT) begin
            r_dig <= {8{BLANK_CODE}};
            r_ovf <= 1'b0;
          end
        end
        StShift: begin
          if (HLT) begin
            r_dig   <= HaltPat;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end else begin
            r_acc   <= {w_adj[38:0], r_shift[31]};
            r_shift <= {r_shift[30:0], 1'b0};
            if (r_cnt == 5'd0) begin
              r_state <= StCommit;
            end else begin
              r_cnt <= r_cnt - 5'd1;
            end
          end
        end
        StCommit: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
          if (HLT) begin
            r_dig <= HaltPat;
            r_ovf <= 1'b0;
          end else begin
            r_dig  <= r_acc[31:0];
            r_ovf  <= |r_acc[39:32];
            r_done <= 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign dmilhao    = r_dig[31:28];
  assign milhao     = r_dig[27:24];
  assign cmilhar    = r_dig[23:20];
  assign dmilhar    = r_dig[19:16];
  assign milhar     = r_dig[15:12];
  assign centesimal = r_dig[11:8];
  assign decimal    = r_dig[7:4];
  assign unidade    = r_dig[3:0];
  assign busy       = r_busy;
  assign done       = r_done;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Directed bench for bcd_display_ctrl: vector table of conversions plus hand-written
// sequences for reset, pattern arbitration, halt abort and back-to-back conversions.
module tb_bcd_display_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        outputEnable;
  logic        flagw;
  logic        notOUT;
  logic        HLT;
  logic [31:0] dataBin;
  logic [3:0]  dmilhao, milhao, cmilhar, dmilhar, milhar, centesimal, decimal, unidade;
  logic        busy;
  logic        done;
  logic        ovf;

  int n_checks = 0;
  int n_errors = 0;

  bcd_display_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .outputEnable(outputEnable),
    .flagw       (flagw),
    .notOUT      (notOUT),
    .HLT         (HLT),
    .dataBin     (dataBin),
    .dmilhao     (dmilhao),
    .milhao      (milhao),
    .cmilhar     (cmilhar),
    .dmilhar     (dmilhar),
    .milhar      (milhar),
    .centesimal  (centesimal),
    .decimal     (decimal),
    .unidade     (unidade),
    .busy        (busy),
    .done        (done),
    .ovf         (ovf)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] din;
    logic [31:0] dig;
    logic        ovf;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [31:0] digs();
    return {dmilhao, milhao, cmilhar, dmilhar, milhar, centesimal, decimal, unidade};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One full conversion from an outputEnable pulse; optionally zero dataBin after edge chg_at.
  task automatic run_conv(input logic [31:0] din, input logic [31:0] exp_dig,
                          input logic exp_ovf, input string name, input int chg_at);
    logic busy_ok;
    dataBin      = din;
    outputEnable = 1'b1;
    tick();
    outputEnable = 1'b0;
    busy_ok = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (!busy || done) busy_ok = 1'b0;
      if (i == chg_at) dataBin = 32'd0;
    end
    check({name, " busy window"}, {31'd0, busy_ok}, 32'd1);
    tick();
    check({name, " done"}, {31'd0, done}, 32'd1);
    check({name, " busy end"}, {31'd0, busy}, 32'd0);
    check({name, " digits"}, digs(), exp_dig);
    check({name, " ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
    tick();
    check({name, " done pulse width"}, {31'd0, done}, 32'd0);
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!done && n < limit);
  endtask

  initial begin
    logic ok;
    logic busy_mid;
    int   n;

    vecs[0] = '{32'd12345678,  32'h12345678, 1'b0};
    vecs[1] = '{32'hFFFFFFFF,  32'h94967295, 1'b1};
    vecs[2] = '{32'd0,         32'h00000000, 1'b0};
    vecs[3] = '{32'd99999999,  32'h99999999, 1'b0};
    vecs[4] = '{32'd4096,      32'h00004096, 1'b0};
    vecs[5] = '{32'd1,         32'h00000001, 1'b0};
    vecs[6] = '{32'd100000000, 32'h00000000, 1'b1};

    reset = 1'b1; outputEnable = 1'b0; flagw = 1'b0; notOUT = 1'b0; HLT = 1'b0;
    dataBin = 32'd0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    check("reset digits", digs(), 32'hAAAAAAAA);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset ovf", {31'd0, ovf}, 32'd0);

    // Reset in the middle of a conversion.
    dataBin = 32'd12345678;
    outputEnable = 1'b1;
    tick();
    outputEnable = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset digits", digs(), 32'hAAAAAAAA);
    check("midreset busy", {31'd0, busy}, 32'd0);
    check("midreset done", {31'd0, done}, 32'd0);
    ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || busy) ok = 1'b0;
    end
    check("midreset no done", {31'd0, ok}, 32'd1);

    for (int i = 0; i < 7; i++) begin
      run_conv(vecs[i].din, vecs[i].dig, vecs[i].ovf, $sformatf("vec%0d", i),
               (i == 0) ? 5 : 0);
    end

    // Halt aborts a conversion of 999; outputEnable pulses while busy are ignored.
    dataBin = 32'd999;
    outputEnable = 1'b1;
    tick();
    outputEnable = 1'b0;
    busy_mid = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      tick();
      outputEnable = (i == 3 || i == 7);
      if (i == 11) busy_mid = busy;
    end
    outputEnable = 1'b0;
    HLT = 1'b1;
    check("halt busy before", {31'd0, busy_mid}, 32'd1);
    tick();
    HLT = 1'b0;
    check("halt digits", digs(), 32'hAAAAACDE);
    check("halt busy", {31'd0, busy}, 32'd0);
    check("halt done", {31'd0, done}, 32'd0);
    check("halt ovf clear", {31'd0, ovf}, 32'd0);
    ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || busy) ok = 1'b0;
    end
    check("halt no later done", {31'd0, ok}, 32'd1);
    check("halt digits held", digs(), 32'hAAAAACDE);

    // Pattern arbitration.
    flagw = 1'b1; notOUT = 1'b1;
    tick();
    check("wait pattern", digs(), 32'hBBBBBBBB);
    flagw = 1'b0;
    tick();
    check("blank pattern", digs(), 32'hAAAAAAAA);
    flagw = 1'b1;
    run_conv(32'd42, 32'h00000042, 1'b0, "oe over flagw", 0);
    flagw = 1'b0; notOUT = 1'b0;
    tick();

    // Back-to-back conversions with outputEnable held high.
    dataBin = 32'd7;
    outputEnable = 1'b1;
    wait_done(40, n);
    check("b2b first done", {31'd0, done}, 32'd1);
    check("b2b first latency", n, 32'd34);
    check("b2b digits", digs(), 32'h00000007);
    wait_done(40, n);
    check("b2b period 1", n, 32'd34);
    wait_done(40, n);
    check("b2b period 2", n, 32'd34);
    check("b2b digits 2", digs(), 32'h00000007);
    outputEnable = 1'b0;
    repeat (40) tick();
    check("b2b idle busy", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bcd_display_ctrl.md
Name: bcd_display_ctrl

Overview:
- Sequential, arbitrated replacement for the combinational binary-to-BCD display path.
- Converts the 32-bit OUT-instruction value to 8 decimal digits using a multi-cycle double-dabble, one bit per clock.
- Arbitrates the 8 seven-segment digit codes between four sources: halt pattern, wait-for-input pattern, no-output pattern and converted value.
- Sits between the processor control unit and the per-digit 7-segment decoders.

Parameters:
- BLANK_CODE, 4'b1010: digit code for a blank/dash segment.
- WAIT_CODE, 4'b1011: digit code shown while the processor waits for input (flagw).
- HLT_U, 4'b1110: units-digit code of the halt pattern.
- HLT_D, 4'b1101: tens-digit code of the halt pattern.
- HLT_C, 4'b1100: hundreds-digit code of the halt pattern.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- outputEnable  in  1  start-conversion request; level, sampled only in IDLE.
- flagw  in  1  input-wait status, level.
- notOUT  in  1  no-output status, level.
- HLT  in  1  processor halted, level; highest priority.
- dataBin  in  32  unsigned value to display; captured on the accepting edge.
- dmilhao, milhao, cmilhar, dmilhar, milhar, centesimal, decimal, unidade  out  4 each  registered digit codes, most significant first.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when converted digits are committed.
- ovf  out  1  set when the committed value exceeds 99,999,999; held until the next commit or pattern load.

Behaviour:
- Reset, applied on any edge and in any state:
  - state goes to IDLE; all 8 digit outputs = BLANK_CODE; busy=0, done=0, ovf=0.
  - the shift register, 40-bit BCD accumulator and bit counter are cleared.
- Digit outputs change only on a commit or a pattern load. They are never updated mid-conversion.
- States: IDLE, SHIFT, COMMIT.
- IDLE, arbitration per edge, in priority order HLT > outputEnable > flagw > notOUT:
  - HLT=1: load halt pattern and clear ovf. Halt pattern: unidade=HLT_U, decimal=HLT_D, centesimal=HLT_C, the other five digits=BLANK_CODE. Stay in IDLE.
  - Else outputEnable=1: capture dataBin into the shift register, clear the accumulator, counter=31, busy=1, go to SHIFT.
  - Else flagw=1: all 8 digits = WAIT_CODE, ovf=0.
  - Else notOUT=1: all 8 digits = BLANK_CODE, ovf=0.
  - Else: hold all outputs.
- SHIFT, one edge per bit:
  - Every 4-bit accumulator nibble (10 nibbles) that is >4 gets +3, evaluated from the pre-edge value.
  - Then {accumulator, shift register} shifts left 1; the shift-register MSB enters accumulator bit 0.
  - If counter==0, go to COMMIT; else counter decrements.
  - Exactly 32 SHIFT edges.
- Inputs during SHIFT:
  - HLT=1 aborts: next edge loads the halt pattern, busy=0, no done pulse, go to IDLE.
  - outputEnable, flagw, notOUT are ignored. There is no queueing.
  - Changes to dataBin after capture are ignored.
- COMMIT, one edge:
  - The lower 8 accumulator nibbles go to the digit outputs.
  - ovf = (upper 2 nibbles != 0).
  - done=1 for exactly this one cycle; busy=0; go to IDLE.
  - HLT=1 in COMMIT takes priority: halt pattern is loaded, no done pulse.
- Latency: accept edge E0, SHIFT edges E1..E32, commit at E33. Digits are valid and done=1 in the cycle after E33. busy is high from after E0 through after E32.
- A held-high outputEnable re-triggers a new conversion on the first IDLE edge after commit. This gives back-to-back conversions with a period of 34 cycles.
- Overflow (values ≥100,000,000): the display shows the lower 8 decimal digits and ovf=1.

Test Plan:
- Reset, then idle with all requests low -> all digits 4'b1010, busy=0, done=0, ovf=0; reset asserted mid-SHIFT at E10 -> same values after the next edge, no done pulse.
- dataBin=32'd12345678, outputEnable pulse at E0 -> busy high E1..E32; after E33 digits 1,2,3,4,5,6,7,8, done=1 for exactly one cycle, ovf=0; dataBin changed to 0 at E5 does not alter the result.
- dataBin=32'hFFFFFFFF -> committed digits 9,4,9,6,7,2,9,5, ovf=1; next conversion of 32'd0 -> all digits 0, ovf=0.
- flagw=1 and notOUT=1 together in IDLE -> all digits 4'b1011; drop flagw -> all digits 4'b1010; raise outputEnable with flagw=1 -> conversion starts (outputEnable wins).
- Conversion of 32'd999 in flight, HLT=1 at SHIFT edge E12 -> after the next edge unidade=1110, decimal=1101, centesimal=1100, others 1010; busy=0, no done; outputEnable pulses while busy are ignored.
- outputEnable held high with dataBin=32'd7 -> done pulses every 34 cycles; digits 0000_0007.
